// File: rtl/lvds_pll_dps_ctrl.sv
// Dynamic-phase-shift sequencer for the LVDS receiver PLL: issues one phase step
// at a time, waits for the phase_done handshake and tracks per-counter phase offsets.
module lvds_pll_dps_ctrl #(
    parameter int unsigned NUM_CNT   = 2,
    parameter int unsigned STEP_W    = 8,
    parameter int unsigned ACC_W     = 10,
    parameter int unsigned EN_CYCLES = 2,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                     scanclk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [4:0]               req_cnt,
    input  logic                     req_dir,
    input  logic [STEP_W-1:0]        req_steps,
    input  logic                     acc_clr,
    input  logic                     pll_locked,
    input  logic                     phase_done,
    output logic                     phase_en,
    output logic                     updn,
    output logic [4:0]               cntsel,
    output logic                     busy,
    output logic                     done,
    output logic                     err_timeout,
    output logic                     err_unlock,
    output logic                     err_badsel,
    output logic [NUM_CNT*ACC_W-1:0] phase_acc
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_WAIT_LO, S_WAIT_HI, S_GAP, S_DONE
    } state_e;

    localparam int unsigned      TMR_W   = $clog2(TIMEOUT + EN_CYCLES + 1);
    localparam logic [TMR_W-1:0] EN_LAST = TMR_W'(EN_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [4:0]       CNT_LIM = 5'(NUM_CNT);

    state_e              state_q, state_d;
    logic [1:0]          lock_sync_q, done_sync_q;
    logic                locked_s, done_s;
    logic [4:0]          cnt_q, cnt_d;
    logic                dir_q, dir_d;
    logic [STEP_W-1:0]   rem_q, rem_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [ACC_W-1:0]    acc_q [NUM_CNT];
    logic [ACC_W-1:0]    acc_d [NUM_CNT];
    logic                err_to_q, err_to_d;
    logic                err_ul_q, err_ul_d;
    logic                err_bs_q, err_bs_d;
    logic                step_ok;

    assign locked_s = lock_sync_q[1];
    assign done_s   = done_sync_q[1];

    always_ff @(posedge scanclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lock_sync_q <= '0;
            done_sync_q <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            rem_q       <= '0;
            tmr_q       <= '0;
            err_to_q    <= 1'b0;
            err_ul_q    <= 1'b0;
            err_bs_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_CNT; i++) acc_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            lock_sync_q <= {lock_sync_q[0], pll_locked};
            done_sync_q <= {done_sync_q[0], phase_done};
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            rem_q       <= rem_d;
            tmr_q       <= tmr_d;
            err_to_q    <= err_to_d;
            err_ul_q    <= err_ul_d;
            err_bs_q    <= err_bs_d;
            acc_q       <= acc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        rem_d    = rem_q;
        tmr_d    = tmr_q;
        err_to_d = 1'b0;
        err_ul_d = 1'b0;
        err_bs_d = 1'b0;
        step_ok  = 1'b0;
        // Lock loss outranks every other event, so it is resolved before the state case.
        if (state_q != S_IDLE && !locked_s) begin
            state_d  = S_IDLE;
            err_ul_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && locked_s) begin
                        if (req_cnt >= CNT_LIM) begin
                            err_bs_d = 1'b1;
                        end else if (req_steps == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_SETUP;
                            cnt_d   = req_cnt;
                            dir_d   = req_dir;
                            rem_d   = req_steps;
                        end
                    end
                end
                S_SETUP: begin
                    tmr_d   = '0;
                    state_d = S_PULSE;
                end
                S_PULSE: begin
                    if (tmr_q == EN_LAST) begin
                        tmr_d   = '0;
                        state_d = S_WAIT_LO;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                S_WAIT_LO: begin
                    if (tmr_q == TO_LAST) begin
                        err_to_d = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                        if (!done_s) state_d = S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (tmr_q == TO_LAST) begin
                        err_to_d = 1'b1;
                        state_d  = S_IDLE;
                    end else if (done_s) begin
                        step_ok = 1'b1;
                        rem_d   = rem_q - 1'b1;
                        state_d = S_GAP;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                S_GAP:   state_d = (rem_q == '0) ? S_DONE : S_SETUP;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            acc_d[i] = acc_q[i];
            if (acc_clr) begin
                acc_d[i] = '0;
            end else if (step_ok && cnt_q == 5'(i)) begin
                acc_d[i] = dir_q ? acc_q[i] + ACC_W'(1) : acc_q[i] - ACC_W'(1);
            end
        end
    end

    always_comb begin
        req_ready   = (state_q == S_IDLE) && locked_s;
        busy        = (state_q != S_IDLE);
        phase_en    = (state_q == S_PULSE);
        done        = (state_q == S_DONE) && locked_s;
        cntsel      = cnt_q;
        updn        = dir_q;
        err_timeout = err_to_q;
        err_unlock  = err_ul_q;
        err_badsel  = err_bs_q;
        phase_acc   = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            phase_acc[i*ACC_W +: ACC_W] = acc_q[i];
        end
    end

endmodule

// File: tb/tb_lvds_pll_dps_ctrl.sv
// Scoreboard bench for lvds_pll_dps_ctrl with a behavioural PLL phase_done model.
module tb_lvds_pll_dps_ctrl;

    localparam int NUM_CNT   = 2;
    localparam int STEP_W    = 8;
    localparam int ACC_W     = 10;
    localparam int EN_CYCLES = 2;
    localparam int TIMEOUT   = 255;

    localparam logic [3:0] K_DONE = 4'b0001;
    localparam logic [3:0] K_TO   = 4'b0010;
    localparam logic [3:0] K_UL   = 4'b0100;
    localparam logic [3:0] K_BS   = 4'b1000;

    logic                     scanclk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     req_valid = 1'b0;
    logic                     req_ready;
    logic [4:0]               req_cnt = '0;
    logic                     req_dir = 1'b0;
    logic [STEP_W-1:0]        req_steps = '0;
    logic                     acc_clr = 1'b0;
    logic                     pll_locked = 1'b0;
    logic                     phase_done = 1'b1;
    logic                     phase_en;
    logic                     updn;
    logic [4:0]               cntsel;
    logic                     busy;
    logic                     done;
    logic                     err_timeout;
    logic                     err_unlock;
    logic                     err_badsel;
    logic [NUM_CNT*ACC_W-1:0] phase_acc;

    lvds_pll_dps_ctrl #(
        .NUM_CNT(NUM_CNT), .STEP_W(STEP_W), .ACC_W(ACC_W),
        .EN_CYCLES(EN_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .scanclk(scanclk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cnt(req_cnt), .req_dir(req_dir), .req_steps(req_steps), .acc_clr(acc_clr),
        .pll_locked(pll_locked), .phase_done(phase_done), .phase_en(phase_en),
        .updn(updn), .cntsel(cntsel), .busy(busy), .done(done),
        .err_timeout(err_timeout), .err_unlock(err_unlock), .err_badsel(err_badsel),
        .phase_acc(phase_acc)
    );

    always #5 scanclk = ~scanclk;

    typedef struct {
        logic [3:0]               kind;
        logic [4:0]               cnt;
        logic                     dir;
        int                       npulse;
        int                       lat;
        int                       t;
        logic [NUM_CNT*ACC_W-1:0] acc;
    } exp_t;

    exp_t             sb[$];
    logic [ACC_W-1:0] m_acc [NUM_CNT];
    int               n_cmp = 0;
    int               n_err = 0;
    int               cyc = 0;
    int               pll_mode = 0;
    int               pd_timer = 0;
    int               pd_rise_n = 0;
    logic             pe_prev_m = 1'b0;
    logic             mon_en = 1'b0;
    logic             mon_pe_prev = 1'b0;
    int               pe_w = 0;
    int               pe_rises = 0;
    int               pe_total = 0;
    int               since_fall = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NUM_CNT*ACC_W-1:0] pack_acc();
        logic [NUM_CNT*ACC_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CNT; i++) r[i*ACC_W +: ACC_W] = m_acc[i];
        return r;
    endfunction

    always @(posedge scanclk) cyc <= cyc + 1;

    // PLL model: phase_done drops 3 clocks after a phase_en rise and returns 4 clocks later.
    initial begin
        forever begin
            @(negedge scanclk);
            if (pll_mode == 0) begin
                if (pd_timer != 0) begin
                    pd_timer++;
                    if (pd_timer == 4) phase_done = 1'b0;
                    if (pd_timer == 8) begin
                        phase_done = 1'b1;
                        pd_timer   = 0;
                        pd_rise_n++;
                    end
                end else if (phase_en && !pe_prev_m) begin
                    pd_timer = 1;
                end
            end else begin
                pd_timer   = 0;
                phase_done = 1'b1;
            end
            pe_prev_m = phase_en;
        end
    end

    initial begin
        logic [3:0] ev;
        exp_t       e;
        forever begin
            @(negedge scanclk);
            if (mon_en) begin
                if (phase_en) pe_w++;
                if (phase_en && !mon_pe_prev) begin
                    pe_rises++;
                    pe_total++;
                    if (sb.size() == 0) begin
                        chk("stray_phase_en", 1, 0);
                    end else begin
                        chk("cntsel", cntsel, sb[0].cnt);
                        chk("updn", updn, sb[0].dir);
                    end
                end
                if (!phase_en && mon_pe_prev) begin
                    chk("pe_width", pe_w, EN_CYCLES);
                    pe_w       = 0;
                    since_fall = 0;
                end else begin
                    since_fall++;
                end
                ev = {err_badsel, err_unlock, err_timeout, done};
                if (ev != 4'b0000) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_event", ev, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("event_kind", ev, e.kind);
                        chk("acc", phase_acc, e.acc);
                        chk("pulse_count", pe_rises, e.npulse);
                        if (e.lat >= 0) chk("latency", cyc - e.t + 1, e.lat);
                        if (e.kind == K_TO) begin
                            chk("to_latency", since_fall, TIMEOUT);
                            chk("to_busy", busy, 0);
                        end
                        if (e.kind == K_BS) chk("badsel_ready", req_ready, 1);
                    end
                    pe_rises = 0;
                end
            end
            mon_pe_prev = phase_en;
        end
    end

    task automatic send(input logic [4:0] c, input logic d, input logic [STEP_W-1:0] s,
                        input logic [3:0] kind, input int np, input int lat,
                        input int dacc, input bit clr_first);
        exp_t e;
        int   ci;
        for (int i = 0; i < 3000 && !req_ready; i++) @(negedge scanclk);
        if (!req_ready) begin
            chk("ready_wait", 0, 1);
            return;
        end
        ci = int'(c);
        if (clr_first) for (int i = 0; i < NUM_CNT; i++) m_acc[i] = '0;
        if (ci < NUM_CNT) m_acc[ci] = m_acc[ci] + ACC_W'(dacc);
        e.kind = kind; e.cnt = c; e.dir = d; e.npulse = np; e.lat = lat;
        e.t = cyc + 1; e.acc = pack_acc();
        sb.push_back(e);
        req_cnt = c; req_dir = d; req_steps = s; req_valid = 1'b1;
        @(negedge scanclk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 8000 && sb.size() != 0; i++) @(negedge scanclk);
        if (sb.size() != 0) begin
            chk("drain", sb.size(), 0);
            sb.delete();
        end
        repeat (12) @(negedge scanclk);
    endtask

    initial begin
        int base;
        int r;
        for (int i = 0; i < NUM_CNT; i++) m_acc[i] = '0;
        repeat (3) @(negedge scanclk);
        chk("rst_outs", {req_ready, busy, phase_en, updn, done, err_timeout,
                         err_unlock, err_badsel, cntsel}, 0);
        chk("rst_acc", phase_acc, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge scanclk);
        chk("ready_unlocked", req_ready, 0);
        pll_locked = 1'b1;
        @(negedge scanclk);
        chk("ready_sync_early", req_ready, 0);
        repeat (2) @(negedge scanclk);
        chk("ready_locked", req_ready, 1);
        mon_en = 1'b1;

        send(5'd1, 1'b1, 8'd1, K_DONE, 1, -1, 1, 1'b0);
        drain();
        send(5'd0, 1'b0, 8'd3, K_DONE, 3, -1, -3, 1'b0);
        drain();
        chk("acc0_minus3", phase_acc[ACC_W-1:0], 10'h3FD);

        pll_mode = 1;
        send(5'd1, 1'b1, 8'd2, K_TO, 1, -1, 0, 1'b0);
        drain();
        pll_mode = 0;

        base = pe_total;
        send(5'd0, 1'b1, 8'd5, K_UL, 2, -1, 1, 1'b0);
        for (int i = 0; i < 200 && pe_total < base + 2; i++) @(posedge scanclk);
        chk("second_pulse_seen", pe_total >= base + 2, 1);
        @(negedge scanclk);
        pll_locked = 1'b0;
        for (int k = 0; k < 3 && phase_en; k++) @(negedge scanclk);
        chk("unlock_pe_low", phase_en, 0);
        drain();
        for (int k = 0; k < 3; k++) begin
            chk("ready_held_unlocked", req_ready, 0);
            repeat (3) @(negedge scanclk);
        end
        pll_locked = 1'b1;
        repeat (4) @(negedge scanclk);
        chk("ready_relock", req_ready, 1);

        send(5'd2, 1'b1, 8'd4, K_BS, 0, 1, 0, 1'b0);
        drain();
        send(5'd1, 1'b0, 8'd0, K_DONE, 0, 1, 0, 1'b0);
        drain();

        acc_clr = 1'b1;
        @(negedge scanclk);
        acc_clr = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) m_acc[i] = '0;
        @(negedge scanclk);
        chk("clr_all", phase_acc, 0);
        send(5'd0, 1'b1, 8'd255, K_DONE, 255, -1, 255, 1'b0);
        drain();
        send(5'd0, 1'b1, 8'd255, K_DONE, 255, -1, 255, 1'b0);
        drain();
        send(5'd0, 1'b1, 8'd1, K_DONE, 1, -1, 1, 1'b0);
        drain();
        chk("acc_1ff", phase_acc[ACC_W-1:0], 10'h1FF);
        send(5'd0, 1'b1, 8'd1, K_DONE, 1, -1, 1, 1'b0);
        drain();
        chk("acc_wrap", phase_acc[ACC_W-1:0], 10'h200);

        send(5'd1, 1'b1, 8'd1, K_DONE, 1, -1, 0, 1'b1);
        r = pd_rise_n;
        for (int i = 0; i < 200 && pd_rise_n == r; i++) @(posedge scanclk);
        chk("pd_rise_seen", pd_rise_n != r, 1);
        @(negedge scanclk);
        @(negedge scanclk);
        acc_clr = 1'b1;
        @(negedge scanclk);
        acc_clr = 1'b0;
        drain();
        chk("clr_collision", phase_acc, 0);

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
